// File: rtl/pedal_pkg.sv
// pedal_pkg: shared sample width, sample type and I2S receiver state encoding
// for the pedal chain.
package pedal_pkg;
   localparam int SAMPLE_W = 16;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} i2s_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an asynchronous level, with
// one-cycle rise and fall pulses derived from the synchronised value.
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end
   assign o_level = r_sync[STAGES-1];
   assign o_rise  = o_level & ~r_prev;
   assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: oversampling I2S ADC deserialiser; publishes left/right pairs
// atomically and drives the left sample to the pedal board as Signal_out.
module i2s_adc_rx
   import pedal_pkg::*;
#(
   parameter int WIDTH       = SAMPLE_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             AUD_BCLK,
   input  logic             AUD_ADCLRCK,
   input  logic             AUD_ADCDAT,
   input  logic             Enable,
   input  logic             Err_clr,
   output logic [WIDTH-1:0] Left_out,
   output logic [WIDTH-1:0] Right_out,
   output logic [WIDTH-1:0] Signal_out,
   output logic             Sample_valid,
   output logic             Frame_err
);
   localparam int CW = $clog2(WIDTH + 1);
   logic             w_bclk, w_bclk_rise, w_lrck, w_dat, w_lr_edge, w_last, w_set_err;
   logic [4:0]       w_unused;
   logic [WIDTH-1:0] w_word;
   i2s_state_t       r_state;
   logic             r_chan, r_lr_prev, r_hold_valid, r_valid, r_err;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_shift, r_left_hold, r_left, r_right;

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk (
      .i_clk(Clk), .i_rst_n(Reset_n), .i_d(AUD_BCLK),
      .o_level(w_bclk), .o_rise(w_bclk_rise), .o_fall(w_unused[0]));
   sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck (
      .i_clk(Clk), .i_rst_n(Reset_n), .i_d(AUD_ADCLRCK),
      .o_level(w_lrck), .o_rise(w_unused[1]), .o_fall(w_unused[2]));
   sync_edge_det #(.STAGES(SYNC_STAGES)) u_dat (
      .i_clk(Clk), .i_rst_n(Reset_n), .i_d(AUD_ADCDAT),
      .o_level(w_dat), .o_rise(w_unused[3]), .o_fall(w_unused[4]));

   assign w_lr_edge = w_lrck != r_lr_prev;
   assign w_word    = {r_shift[WIDTH-2:0], w_dat};
   assign w_last    = r_cnt == CW'(WIDTH - 1);
   assign w_set_err = Enable && w_bclk_rise && w_lr_edge && (r_state == DELAY || r_state == SHIFT);

   // The bit seen on the LRCK edge itself is the I2S delay bit and is never
   // stored; DELAY therefore receives the MSB on its first bclk_rise.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= IDLE;
         r_chan       <= 1'b0;
         r_lr_prev    <= 1'b0;
         r_hold_valid <= 1'b0;
         r_valid      <= 1'b0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_left_hold  <= '0;
         r_left       <= '0;
         r_right      <= '0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= w_set_err | (r_err & ~Err_clr);
         if (w_bclk_rise) r_lr_prev <= w_lrck;
         if (!Enable) begin
            r_state      <= IDLE;
            r_hold_valid <= 1'b0;
         end else if (w_bclk_rise) begin
            case (r_state)
               IDLE: if (w_lr_edge && !w_lrck) begin
                  r_state <= DELAY;
                  r_chan  <= 1'b0;
                  r_cnt   <= '0;
               end
               DELAY, SHIFT: if (w_lr_edge) begin
                  r_state      <= DELAY;
                  r_chan       <= w_lrck;
                  r_cnt        <= '0;
                  r_hold_valid <= 1'b0;
               end else begin
                  r_shift <= w_word;
                  r_cnt   <= r_cnt + CW'(1);
                  r_state <= w_last ? PAD : SHIFT;
                  if (w_last && !r_chan) begin
                     r_left_hold  <= w_word;
                     r_hold_valid <= 1'b1;
                  end
                  if (w_last && r_chan && r_hold_valid) begin
                     r_left       <= r_left_hold;
                     r_right      <= w_word;
                     r_valid      <= 1'b1;
                     r_hold_valid <= 1'b0;
                  end
               end
               default: if (w_lr_edge) begin
                  r_state <= DELAY;
                  r_chan  <= w_lrck;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign Left_out     = r_left;
   assign Right_out    = r_right;
   assign Signal_out   = r_left;
   assign Sample_valid = r_valid;
   assign Frame_err    = r_err;
endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: drives a jittered I2S stream (LRCK/DAT change on BCLK fall,
// MSB one bit after the LRCK change) and checks against a frame-level model.
`timescale 1ns/1ps
module tb_i2s_adc_rx;
   import pedal_pkg::*;
   logic clk = 0, rst_n = 1, bclk = 0, lrck = 0, dat = 0, en = 1, err_clr = 0;
   logic [SAMPLE_W-1:0] left_out, right_out, signal_out;
   logic valid, frame_err;
   int errors = 0, checks = 0, pulses = 0;
   logic [SAMPLE_W-1:0] exp_l[$], exp_r[$];
   logic [SAMPLE_W-1:0] cur_l = 0, cur_r = 0, m_hold = 0;
   logic prev_valid = 0, m_prev_lr = 0, m_track = 0, m_ok = 0, m_err = 0;

   always #10 clk = ~clk;

   i2s_adc_rx #(.WIDTH(SAMPLE_W), .SYNC_STAGES(2)) dut (
      .Clk(clk), .Reset_n(rst_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
      .Enable(en), .Err_clr(err_clr), .Left_out(left_out), .Right_out(right_out),
      .Signal_out(signal_out), .Sample_valid(valid), .Frame_err(frame_err));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // One BCLK period: data/LRCK launched on the falling edge, sampled on the rise.
   task automatic bit_period(input logic lr, input logic d);
      bclk = 0; lrck = lr; dat = d;
      #(160 + $urandom_range(0, 6));
      bclk = 1;
      #(160 + $urandom_range(0, 6));
   endtask

   // Slot-level model: a slot is captured only once a left-slot LRCK edge has
   // been seen while enabled; a slot shorter than WIDTH+1 BCLKs is a framing error.
   task automatic send_slot(input logic ch, input int n, input logic [SAMPLE_W-1:0] w);
      if (!en) begin
         m_track = 0; m_ok = 0;
      end else if (ch != m_prev_lr) begin
         if (!ch) m_track = 1;
         if (m_track) begin
            if (n < SAMPLE_W + 1) begin m_err = 1; m_ok = 0; end
            else if (!ch) begin m_hold = w; m_ok = 1; end
            else if (m_ok) begin exp_l.push_back(m_hold); exp_r.push_back(w); m_ok = 0; end
         end
      end
      m_prev_lr = ch;
      for (int k = 0; k < n; k++)
         bit_period(ch, (k >= 1 && k <= SAMPLE_W) ? w[SAMPLE_W-k] : 1'($urandom));
   endtask

   task automatic send_frame(input int n, input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
      send_slot(1'b0, n, l);
      send_slot(1'b1, n, r);
   endtask

   task automatic do_reset();
      rst_n = 0; bclk = 0;
      exp_l.delete(); exp_r.delete();
      m_prev_lr = 0; m_track = 0; m_ok = 0; m_err = 0;
      #1;
      chk("rst_left", left_out, 0);
      chk("rst_right", right_out, 0);
      chk("rst_signal", signal_out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", frame_err, 0);
      repeat (4) @(negedge clk);
      #3 rst_n = 1;
      repeat (4) @(negedge clk);
   endtask

   // Per-cycle compare against the published-pair scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("hold_rst_left", left_out, 0);
         chk("hold_rst_right", right_out, 0);
         chk("hold_rst_valid", valid, 0);
         cur_l = 0; cur_r = 0;
      end else begin
         if (valid) begin
            pulses++;
            chk("pulse_width", prev_valid, 0);
            chk("pending_pair", 32'(exp_l.size() != 0), 1);
            if (exp_l.size() != 0) begin
               cur_l = exp_l.pop_front();
               cur_r = exp_r.pop_front();
            end
         end
         chk("left_out", left_out, cur_l);
         chk("right_out", right_out, cur_r);
         chk("signal_out", signal_out, cur_l);
      end
      prev_valid = valid;
   end

   initial begin
      #(4_000_000);
      $display("FAIL watchdog: time limit reached after %0d checks", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      #2;
      do_reset();
      #($urandom_range(0, 19));
      p0 = pulses;
      send_slot(1'b1, 32, 16'h0000);
      send_frame(32, 16'h1234, 16'hABCD);
      chk("t1_left", left_out, 16'h1234);
      chk("t1_signal", signal_out, 16'h1234);
      chk("t1_right", right_out, 16'hABCD);
      chk("t1_err", frame_err, 0);
      chk("t1_pulses", pulses - p0, 1);

      do_reset();
      p0 = pulses;
      send_slot(1'b1, 10, 16'h3C3C);
      send_frame(24, 16'h8000, 16'h7FFF);
      chk("t2_left", left_out, 16'h8000);
      chk("t2_right", right_out, 16'h7FFF);
      chk("t2_pulse_cycles", pulses - p0, 1);

      p0 = pulses;
      send_slot(1'b0, 10, 16'hDEAD);
      send_slot(1'b1, 24, 16'hBEEF);
      send_frame(24, 16'h0F0F, 16'hF0F0);
      chk("t3_err", frame_err, 1);
      chk("t3_err_model", frame_err, m_err);
      chk("t3_left", left_out, 16'h0F0F);
      chk("t3_right", right_out, 16'hF0F0);
      chk("t3_pulses", pulses - p0, 1);
      @(negedge clk) err_clr = 1;
      @(negedge clk) err_clr = 0;
      m_err = 0;
      @(negedge clk);
      chk("t3_err_clr", frame_err, 0);

      p0 = pulses;
      send_frame(24, 16'h5555, 16'hAAAA);
      en = 0;
      send_frame(24, 16'h1111, 16'h2222);
      send_frame(24, 16'h3333, 16'h4444);
      chk("t4_hold_left", left_out, 16'h5555);
      chk("t4_hold_right", right_out, 16'hAAAA);
      chk("t4_no_pulse", pulses - p0, 1);
      en = 1;
      send_frame(20, 16'h6789, 16'h0123);
      chk("t4_resume_left", left_out, 16'h6789);
      chk("t4_resume_pulses", pulses - p0, 2);

      send_slot(1'b0, 24, 16'h1357);
      for (int k = 0; k < 8; k++) bit_period(1'b1, 1'($urandom));
      do_reset();
      p0 = pulses;
      send_slot(1'b1, 12, 16'h0000);
      send_frame(24, 16'h2468, 16'h9BDF);
      chk("t5_left", left_out, 16'h2468);
      chk("t5_right", right_out, 16'h9BDF);
      chk("t5_pulses", pulses - p0, 1);

      p0 = pulses;
      for (int i = 0; i < 100; i++)
         send_frame($urandom_range(17, 19), 16'($urandom), 16'($urandom));
      repeat (10) @(negedge clk);
      chk("rand_pulses", pulses - p0, 100);
      chk("rand_pending", exp_l.size(), 0);
      chk("rand_err", frame_err, m_err);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
